// File: rtl/aes_inv_cipher_iter_pkg.sv
// Shared definitions for the iterative AES inverse cipher.
//   AES_BLOCK_W          : width of one AES block in bits
//   inv_fsm_t            : control states of the iterative core
//   inv_sbox()           : inverse S-box lookup (256-entry table)
//   inv_shift_rows()     : InvShiftRows on a 128-bit state
//   galois_mult_*()      : GF(2^8) constant multipliers
//   inverse_mix_columns(): InvMixColumns on a 128-bit state
// Byte k of a block sits at [127-8k -: 8]; byte k is row k%4 of column k/4.
package aes_inv_cipher_iter_pkg;

   localparam int AES_BLOCK_W = 128;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } inv_fsm_t;

   // Entry 0x00 is the top byte, entry 0xff the bottom byte.
   localparam logic [2047:0] INV_SBOX_TBL = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      logic [10:0] idx;
      // (255 - b) * 8 selects the entry counted from the LSB end
      idx = {~b, 3'b000};
      return INV_SBOX_TBL[idx +: 8];
   endfunction

   // Row r is rotated right by r: new[r][c] = old[r][(c - r) mod 4]
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = 128'h0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [7:0] galois_mult_2(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] galois_mult_9(input logic [7:0] a);
      return galois_mult_2(galois_mult_2(galois_mult_2(a))) ^ a;
   endfunction

   function automatic logic [7:0] galois_mult_11(input logic [7:0] a);
      return galois_mult_2(galois_mult_2(galois_mult_2(a)) ^ a) ^ a;
   endfunction

   function automatic logic [7:0] galois_mult_13(input logic [7:0] a);
      return galois_mult_2(galois_mult_2(galois_mult_2(a) ^ a)) ^ a;
   endfunction

   function automatic logic [7:0] galois_mult_14(input logic [7:0] a);
      return galois_mult_2(galois_mult_2(galois_mult_2(a) ^ a) ^ a);
   endfunction

   function automatic logic [127:0] inverse_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = 128'h0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = galois_mult_14(a0) ^ galois_mult_11(a1) ^ galois_mult_13(a2) ^ galois_mult_9(a3);
         o[119-32*c -: 8] = galois_mult_9(a0)  ^ galois_mult_14(a1) ^ galois_mult_11(a2) ^ galois_mult_13(a3);
         o[111-32*c -: 8] = galois_mult_13(a0) ^ galois_mult_9(a1)  ^ galois_mult_14(a2) ^ galois_mult_11(a3);
         o[103-32*c -: 8] = galois_mult_11(a0) ^ galois_mult_13(a1) ^ galois_mult_9(a2)  ^ galois_mult_14(a3);
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_round_comb.sv
// One AES decryption round, purely combinational.
//   state  : current cipher state
//   rk     : round key for this round
//   last   : final round, skip InvMixColumns
//   result : InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk), or without
//            InvMixColumns when last is set
module aes_inv_round_comb
   import aes_inv_cipher_iter_pkg::*;
(
   input  logic [AES_BLOCK_W-1:0] state,
   input  logic [AES_BLOCK_W-1:0] rk,
   input  logic                   last,
   output logic [AES_BLOCK_W-1:0] result
);

   logic [AES_BLOCK_W-1:0] shifted_s;
   logic [AES_BLOCK_W-1:0] subbed_s;
   logic [AES_BLOCK_W-1:0] added_s;

   // Round datapath: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
   always_comb begin
      shifted_s = inv_shift_rows(state);
      subbed_s  = {AES_BLOCK_W{1'b0}};
      for (int k = 0; k < 16; k++) begin
         subbed_s[127-8*k -: 8] = inv_sbox(shifted_s[127-8*k -: 8]);
      end
      added_s = subbed_s ^ rk;
      if (last) begin
         result = added_s;
      end else begin
         result = inverse_mix_columns(added_s);
      end
   end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher, one decryption round per clock.
//   clk, rst           : clock (rising edge), synchronous active-high reset
//   in_valid/in_ready  : ciphertext handshake, data_in carries the block
//   rk_idx / rk        : round-key request and its same-cycle return
//   out_valid/out_ready: plaintext handshake, data_out carries the block
// Accept in IDLE does the initial AddRoundKey with key NUM_ROUNDS, ROUND runs
// rounds NUM_ROUNDS-1 down to 0, DONE spends one cycle loading data_out and
// then holds it until the downstream handshake.
module aes_inv_cipher_iter
   import aes_inv_cipher_iter_pkg::*;
#(
   parameter int NUM_ROUNDS = 10,
   parameter int RK_IDX_W   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AES_BLOCK_W-1:0] data_in,
   output logic [RK_IDX_W-1:0]    rk_idx,
   input  logic [AES_BLOCK_W-1:0] rk,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AES_BLOCK_W-1:0] data_out
);

   localparam logic [RK_IDX_W-1:0] RND_INIT  = RK_IDX_W'(NUM_ROUNDS);
   localparam logic [RK_IDX_W-1:0] RND_FIRST = RK_IDX_W'(NUM_ROUNDS - 1);
   localparam logic [RK_IDX_W-1:0] RND_ONE   = RK_IDX_W'(1);
   localparam logic [RK_IDX_W-1:0] RND_ZERO  = RK_IDX_W'(0);

   inv_fsm_t               fsm_r,       fsm_s;
   logic [RK_IDX_W-1:0]    rnd_r,       rnd_s;
   logic [AES_BLOCK_W-1:0] state_reg_r, state_reg_s;
   logic                   in_ready_s;
   logic                   out_valid_s;
   logic [AES_BLOCK_W-1:0] data_out_s;
   logic                   last_s;
   logic [AES_BLOCK_W-1:0] round_out_s;

   // rnd holds NUM_ROUNDS in IDLE, so it doubles as the key index in every state
   assign rk_idx = rnd_r;
   assign last_s = (rnd_r == RND_ZERO);

   aes_inv_round_comb u_round (
      .state  (state_reg_r),
      .rk     (rk),
      .last   (last_s),
      .result (round_out_s)
   );

   // Next-state and next-output logic for the IDLE/ROUND/DONE controller
   always_comb begin
      fsm_s       = fsm_r;
      rnd_s       = rnd_r;
      state_reg_s = state_reg_r;
      in_ready_s  = in_ready;
      out_valid_s = out_valid;
      data_out_s  = data_out;
      case (fsm_r)
         IDLE: begin
            if (in_valid) begin
               state_reg_s = data_in ^ rk;
               rnd_s       = RND_FIRST;
               in_ready_s  = 1'b0;
               fsm_s       = ROUND;
            end else begin
               in_ready_s  = 1'b1;
            end
         end
         ROUND: begin
            state_reg_s = round_out_s;
            if (last_s) begin
               fsm_s = DONE;
            end else begin
               rnd_s = rnd_r - RND_ONE;
            end
         end
         DONE: begin
            // out_valid is still low on the first DONE cycle, so out_ready cannot act yet
            if (!out_valid) begin
               out_valid_s = 1'b1;
               data_out_s  = state_reg_r;
            end else if (out_ready) begin
               out_valid_s = 1'b0;
               in_ready_s  = 1'b1;
               rnd_s       = RND_INIT;
               fsm_s       = IDLE;
            end else begin
               out_valid_s = 1'b1;
            end
         end
         default: begin
            fsm_s       = IDLE;
            rnd_s       = RND_INIT;
            in_ready_s  = 1'b1;
            out_valid_s = 1'b0;
         end
      endcase
   end

   // Controller, round state and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_r       <= IDLE;
         rnd_r       <= RND_INIT;
         state_reg_r <= {AES_BLOCK_W{1'b0}};
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         data_out    <= {AES_BLOCK_W{1'b0}};
      end else begin
         fsm_r       <= fsm_s;
         rnd_r       <= rnd_s;
         state_reg_r <= state_reg_s;
         in_ready    <= in_ready_s;
         out_valid   <= out_valid_s;
         data_out    <= data_out_s;
      end
   end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Scoreboard bench for aes_inv_cipher_iter: the driver pushes the expected
// plaintext on each accept, a monitor pops and compares on each output handshake.
// Round keys come from a forward AES-128 reference model (key expansion and
// encryption) built from first principles.
module tb_aes_inv_cipher_iter;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] data_in;
   logic [3:0]   rk_idx;
   logic [127:0] rk;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] data_out;

   int           total = 0;
   int           bad   = 0;
   int           cyc   = 0;
   int           acc_edge = 0;
   logic [127:0] exp_q[$];
   logic [127:0] rks [0:10];
   logic [7:0]   sb  [0:255];

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

   aes_inv_cipher_iter dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .rk_idx    (rk_idx),
      .rk        (rk),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out)
   );

   assign rk = (rk_idx <= 4'd10) ? rks[rk_idx] : 128'h0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   // Forward S-box from the GF(2^8) inverse plus the affine transform
   task automatic build_sbox();
      logic [7:0] inv;
      for (int i = 0; i < 256; i++) begin
         inv = 8'h01;
         if (i == 0) inv = 8'h00;
         else for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(i));
         sb[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic key_expand(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
            t[31:24] = t[31:24] ^ rc;
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] encrypt(input logic [127:0] pt);
      logic [127:0] s, u, m;
      logic [7:0]   a0, a1, a2, a3;
      s = pt ^ rks[0];
      for (int r = 1; r <= 10; r++) begin
         u = 128'h0;
         for (int c = 0; c < 4; c++)
            for (int q = 0; q < 4; q++)
               u[127-8*(4*c+q) -: 8] = sb[s[127-8*(4*((c+q)%4)+q) -: 8]];
         if (r < 10) begin
            m = 128'h0;
            for (int c = 0; c < 4; c++) begin
               a0 = u[127-32*c -: 8]; a1 = u[119-32*c -: 8];
               a2 = u[111-32*c -: 8]; a3 = u[103-32*c -: 8];
               m[127-32*c -: 8] = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
               m[119-32*c -: 8] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
               m[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
               m[103-32*c -: 8] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
            end
            u = m;
         end
         s = u ^ rks[r];
      end
      return s;
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send_block(input logic [127:0] ct, input logic [127:0] pt, input bit hold);
      int n = 0;
      bit done = 1'b0;
      in_valid = 1'b1;
      data_in  = ct;
      while (!done && n < 40) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(pt);
            acc_edge = cyc + 1;
            done = 1'b1;
         end else begin
            n++;
         end
      end
      if (!done) begin
         total++; bad++;
         $display("FAIL accept_timeout: in_ready low for %0d cycles", n);
      end
      tick();
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         total++; bad++;
         $display("FAIL drain_timeout: %0d blocks pending, expected 0", exp_q.size());
         exp_q.delete();
      end
      tick();
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic prev_ov = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_ov = 1'b0;
         end else begin
            if (out_valid && !prev_ov) chk("latency", 128'(cyc - acc_edge), 128'd11);
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_output: got %h expected none", data_out);
               end else begin
                  chk("plaintext", data_out, exp_q.pop_front());
               end
            end
            prev_ov = out_valid;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int a1;
      logic [127:0] pt2, ct2, key, pt;
      rst = 1'b1; in_valid = 1'b0; data_in = 128'h0; out_ready = 1'b1;
      build_sbox();
      key_expand(C1_KEY);
      repeat (3) tick();

      // reset state
      @(negedge clk);
      chk("rst_in_ready", 128'(in_ready), 128'd1);
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_data_out", data_out, 128'h0);
      chk("rst_rk_idx", 128'(rk_idx), 128'd10);
      tick();
      rst = 1'b0;
      tick();

      // 1. FIPS-197 C.1 with round-key index sequence
      @(negedge clk);
      chk("idle_rk_idx", 128'(rk_idx), 128'd10);
      tick();
      send_block(C1_CT, C1_PT, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("rk_idx_seq", 128'(rk_idx), 128'(9 - i));
      end
      wait_drain();

      // 2. output backpressure
      out_ready = 1'b0;
      send_block(C1_CT, C1_PT, 1'b0);
      begin
         int n = 0;
         while (!out_valid && n < 40) begin @(negedge clk); n++; end
      end
      for (int i = 0; i < 5; i++) begin
         chk("bp_out_valid", 128'(out_valid), 128'd1);
         chk("bp_data_out", data_out, C1_PT);
         chk("bp_in_ready", 128'(in_ready), 128'd0);
         @(negedge clk);
      end
      tick();
      out_ready = 1'b1;
      tick();
      @(negedge clk);
      chk("bp_idle_in_ready", 128'(in_ready), 128'd1);
      chk("bp_idle_out_valid", 128'(out_valid), 128'd0);
      tick();

      // 3. in_valid held with changing data while busy
      send_block(C1_CT, C1_PT, 1'b1);
      for (int i = 0; i < 9; i++) begin
         data_in = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         chk("busy_in_ready", 128'(in_ready), 128'd0);
         tick();
      end
      in_valid = 1'b0;
      wait_drain();

      // 4. reset in the middle of a block
      send_block(C1_CT, C1_PT, 1'b0);
      repeat (4) tick();
      rst = 1'b1;
      tick();
      @(negedge clk);
      chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
      chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
      chk("mid_rst_data_out", data_out, 128'h0);
      chk("mid_rst_rk_idx", 128'(rk_idx), 128'd10);
      void'(exp_q.pop_back());
      tick();
      rst = 1'b0;
      tick();
      send_block(C1_CT, C1_PT, 1'b0);
      wait_drain();

      // 5. back-to-back blocks with out_ready tied high
      pt2 = 128'hfedcba98765432100123456789abcdef;
      ct2 = encrypt(pt2);
      send_block(C1_CT, C1_PT, 1'b0);
      a1 = acc_edge;
      send_block(ct2, pt2, 1'b0);
      chk("b2b_spacing", 128'(acc_edge - a1), 128'd13);
      wait_drain();

      // 6. random key/plaintext sweep
      for (int i = 0; i < 1000; i++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         pt  = {$urandom, $urandom, $urandom, $urandom};
         key_expand(key);
         send_block(encrypt(pt), pt, 1'b0);
         wait_drain();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
